// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage of the RISC-V core.
//
// Owns the PC, fetches one word at a time from a variable-latency instruction
// memory (req/gnt/rvalid, single outstanding request) and hands each word to
// decode over a valid/ready handshake. Branch/jump redirects arrive from
// execute as base + sign-extended immediate.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect whose target has bit 1 set parks the unit in TRAP
//               (no fetch, misalign_exc=1) until an aligned redirect or reset.
//   undefined : target bits [1:0] are forced to 0, misalign_exc is tied low.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   imem_req       fetch request, held with a stable imem_addr until imem_gnt
//   imem_addr      word-aligned fetch address
//   imem_gnt       memory accepted the request this cycle
//   imem_rvalid    read data valid (never in the same cycle as its gnt)
//   imem_rdata     read data
//   instr_valid    instr/instr_pc/pc_plus4 valid for decode
//   instr_ready    decode accepts the instruction
//   instr          fetched instruction, NOP_INSN while nothing is valid
//   instr_pc       address of instr
//   pc_plus4       instr_pc + 4, link value for JAL/JALR
//   redirect       load a new PC (branch taken / jump)
//   redirect_base  target base: branch PC, or rs1 for JALR
//   redirect_jalr  clear target bit 0
//   imm_ext        sign-extended immediate from the extender
//   misalign_exc   instruction-address-misaligned flag
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INSN = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_base,
    input  logic            redirect_jalr,
    input  logic [XLEN-1:0] imm_ext,
    output logic            misalign_exc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            kill_q, kill_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            go_req;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;

    // Redirect target wraps modulo 2^XLEN; JALR drops bit 0.
    assign target_sum = redirect_base + imm_ext;

    always_comb begin
        target = target_sum;
        if (redirect_jalr) begin
            target[0] = 1'b0;
        end
`ifndef FETCH_MISALIGN_TRAP_EN
        target[1:0] = 2'b00;
`endif
    end

    // The request address lives in its own register: a redirect that lands
    // while a request is still waiting for gnt moves fetch_pc, but the
    // in-flight request must complete at its original address.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        go_req     = 1'b0;
        imem_req   = 1'b0;

        if (redirect) begin
            fetch_pc_d = target;
        end else if (state_q == S_HOLD && instr_ready) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        case (state_q)
            S_IDLE: begin
                go_req = 1'b1;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
                // The accepted (or still pending) request fetches the old
                // address; remember to throw its data away.
                if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect) begin
                        kill_d = 1'b0;
                        go_req = 1'b1;
                    end else begin
                        instr_d = imem_rdata;
                        pc_d    = addr_q;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                // A redirect coinciding with ready still completes the
                // transfer; only the next PC differs (handled above).
                if (redirect || instr_ready) begin
                    valid_d = 1'b0;
                    go_req  = 1'b1;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                if (redirect) begin
                    go_req = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every path that starts a new fetch goes through here so the request
        // address always follows the freshest PC.
        if (go_req) begin
            addr_d = {fetch_pc_d[XLEN-1:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            state_d = fetch_pc_d[1] ? S_TRAP : S_REQ;
`else
            state_d = S_REQ;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= NOP_INSN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = valid_q ? instr_q : NOP_INSN;
    assign instr_pc    = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_exc = (state_q == S_TRAP);
`else
    assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        redirect = 1'b0;
    logic [31:0] redirect_base = 32'h0;
    logic        redirect_jalr = 1'b0;
    logic [31:0] imm_ext = 32'h0;
    logic        misalign_exc;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .pc_plus4     (pc_plus4),
        .redirect     (redirect),
        .redirect_base(redirect_base),
        .redirect_jalr(redirect_jalr),
        .imm_ext      (imm_ext),
        .misalign_exc (misalign_exc)
    );

    initial forever #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Architectural next PC after a redirect, as seen by the fetch address.
    function automatic logic [31:0] tgt_fn(input logic [31:0] b, input logic [31:0] i, input logic j);
        logic [31:0] t;
        t = b + i;
        if (j) t[0] = 1'b0;
        t[1:0] = 2'b00;
        return t;
    endfunction

    // Controls written only by the main process.
    int          mem_gnt_dly = 0;   // <0: random 0..3
    int          mem_rv_dly  = 0;
    bit          rand_mode   = 0;
    bit          dir_ready   = 0;
    bit          dir_redirect = 0;
    logic [31:0] dir_base    = 0;
    logic [31:0] dir_imm     = 0;
    bit          dir_jalr    = 0;
    bit          inject_rv   = 0;

    // State written only by the monitor process.
    logic [31:0] grant_log[$];
    bit          inject_seen = 0;
    bit          pend = 0;
    int          g_cnt = 0, rv_cnt = 0;
    logic [31:0] pend_addr = 0;
    logic [31:0] exp_pc = 0;
    int          idle = 0;
    bit          prev_valid, prev_ready, prev_redirect, prev_req, prev_gnt;
    logic [31:0] prev_target, prev_instr, prev_pc, prev_addr;

    function automatic int pick(input int d);
        return (d < 0) ? int'($urandom_range(0, 3)) : d;
    endfunction

    // Memory responder, decode-side driver and reference model; sampled and
    // driven on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 0; imem_gnt = 0; imem_rvalid = 0;
                g_cnt = pick(mem_gnt_dly);
                exp_pc = RESET_PC; idle = 0;
                prev_valid = 0; prev_ready = 0; prev_redirect = 0; prev_req = 0; prev_gnt = 0;
                prev_target = 0; prev_instr = 0; prev_pc = 0; prev_addr = 0;
            end else begin
                bit exp_low;
                exp_low = 0;
                if (prev_redirect) begin
                    exp_pc = prev_target; exp_low = 1;
                end else if (prev_valid && prev_ready) begin
                    exp_pc = exp_pc + 32'd4; exp_low = 1;
                end
                if (exp_low) chk("valid_drop", instr_valid, 1'b0);
                if (instr_valid) begin
                    chk("instr_pc", instr_pc, exp_pc);
                    chk("instr_data", instr, mem_fn(instr_pc));
                    chk("pc_plus4", pc_plus4, instr_pc + 32'd4);
                    idle = 0;
                end else begin
                    chk("instr_nop", instr, NOP_INSN);
                    idle++;
                    if (idle > 60) begin
                        chk("progress_stall", idle, 0);
                        idle = 0;
                    end
                end
                if (prev_valid && !prev_ready && !prev_redirect) begin
                    chk("hold_valid", instr_valid, 1'b1);
                    chk("hold_instr", instr, prev_instr);
                    chk("hold_pc", instr_pc, prev_pc);
                end
                if (prev_req && !prev_gnt) begin
                    chk("req_held", imem_req, 1'b1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                if (imem_req) begin
                    chk("single_outstanding", pend || instr_valid, 1'b0);
                    chk("addr_aligned", imem_addr[1:0], 2'b00);
                end
`ifndef FETCH_MISALIGN_TRAP_EN
                chk("misalign_low", misalign_exc, 1'b0);
`endif
                // memory response for the coming edge
                imem_gnt = 0; imem_rvalid = 0; imem_rdata = $urandom;
                if (inject_rv != inject_seen) begin
                    inject_seen = inject_rv;
                    imem_rvalid = 1;
                end else if (pend) begin
                    if (rv_cnt == 0) begin
                        imem_rvalid = 1; imem_rdata = mem_fn(pend_addr); pend = 0;
                    end else rv_cnt--;
                end else if (imem_req) begin
                    if (g_cnt == 0) begin
                        imem_gnt = 1; pend = 1; pend_addr = imem_addr;
                        grant_log.push_back(imem_addr);
                        rv_cnt = pick(mem_rv_dly);
                        g_cnt = pick(mem_gnt_dly);
                    end else g_cnt--;
                end
            end
            // decode side
            if (rand_mode) begin
                instr_ready   = ($urandom_range(0, 9) < 7);
                redirect      = ($urandom_range(0, 11) == 0);
                redirect_base = $urandom & ~32'h2;
                imm_ext       = $urandom & ~32'h3;
                redirect_jalr = 1'($urandom_range(0, 1));
            end else begin
                instr_ready = dir_ready; redirect = dir_redirect;
                redirect_base = dir_base; imm_ext = dir_imm; redirect_jalr = dir_jalr;
            end
            prev_valid = instr_valid; prev_ready = instr_ready; prev_redirect = redirect;
            prev_target = tgt_fn(redirect_base, imm_ext, redirect_jalr);
            prev_instr = instr; prev_pc = instr_pc;
            prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input bit late);
        tick();
        rst_n = 0;
        tick(); tick();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        rst_n = 1;
        if (late) inject_rv = ~inject_rv;
    endtask

    task automatic wait_valid(input string name, input int bound);
        int n;
        n = 0;
        while (!instr_valid && n < bound) begin tick(); n++; end
        chk(name, instr_valid, 1'b1);
    endtask

    task automatic do_redirect(input logic [31:0] b, input logic [31:0] i, input bit j);
        dir_base = b; dir_imm = i; dir_jalr = j; dir_redirect = 1;
        tick();
        dir_redirect = 0;
    endtask

    int n, m, lb;
    logic [31:0] h_instr, h_pc;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", imem_req, 1'b0);
        chk("reset_addr", imem_addr, RESET_PC);
        chk("reset_valid", instr_valid, 1'b0);
        chk("reset_instr", instr, NOP_INSN);
        chk("reset_pc", instr_pc, RESET_PC);
        chk("reset_plus4", pc_plus4, RESET_PC + 32'd4);
        chk("reset_misalign", misalign_exc, 1'b0);

        // back-to-back fetch with the fastest memory
        mem_gnt_dly = 0; mem_rv_dly = 0; dir_ready = 1;
        lb = grant_log.size();
        rst_n = 1;
        n = 0;
        while (!imem_req && n < 10) begin tick(); n++; end
        chk("t1_req_seen", imem_req, 1'b1);
        m = 0;
        while (!instr_valid && m < 10) begin tick(); m++; end
        chk("t1_valid_latency", m, 2);
        repeat (12) tick();
        if (grant_log.size() >= lb + 3) begin
            chk("t1_addr0", grant_log[lb], 32'h0);
            chk("t1_addr1", grant_log[lb+1], 32'h4);
            chk("t1_addr2", grant_log[lb+2], 32'h8);
        end else chk("t1_grant_count", grant_log.size() - lb, 3);

        // slow memory, plus a stray rvalid right after reset release
        mem_gnt_dly = 3; mem_rv_dly = 2; dir_ready = 0;
        do_reset(1);
        n = 0;
        while (!imem_req && n < 10) begin tick(); n++; end
        m = 0;
        while (!instr_valid && m < 30) begin tick(); m++; end
        chk("t2_latency", m, 7);
        chk("t2_pc", instr_pc, 32'h0);
        chk("t2_instr", instr, mem_fn(32'h0));

        // redirect during WAIT: stale data dropped, wrap-around target
        mem_gnt_dly = 0; mem_rv_dly = 3;
        do_reset(0);
        lb = grant_log.size();
        n = 0;
        while (!imem_req && n < 10) begin tick(); n++; end
        tick();
        chk("t3_in_wait", imem_req, 1'b0);
        do_redirect(32'h0000_0100, 32'hFFFF_FFF8, 1'b0);
        wait_valid("t3_valid_timeout", 40);
        chk("t3_pc", instr_pc, 32'h0000_00F8);
        chk("t3_instr", instr, mem_fn(32'h0000_00F8));
        if (grant_log.size() >= lb + 2) chk("t3_next_addr", grant_log[lb+1], 32'h0000_00F8);
        else chk("t3_grant_count", grant_log.size() - lb, 2);

        // JALR redirect from HOLD, then a long stall in HOLD
        mem_rv_dly = 0;
        do_reset(0);
        wait_valid("t4_first_timeout", 20);
        do_redirect(32'h0000_0201, 32'h0, 1'b1);
        chk("t4_drop", instr_valid, 1'b0);
        wait_valid("t4_valid_timeout", 20);
        chk("t4_pc", instr_pc, 32'h0000_0200);
        chk("t4_plus4", pc_plus4, 32'h0000_0204);
        chk("t4_instr", instr, mem_fn(32'h0000_0200));
        h_instr = instr; h_pc = instr_pc;
        repeat (5) begin
            tick();
            chk("t5_valid", instr_valid, 1'b1);
            chk("t5_instr", instr, h_instr);
            chk("t5_pc", instr_pc, h_pc);
            chk("t5_no_req", imem_req, 1'b0);
        end
        dir_ready = 1;
        tick();
        dir_ready = 0;
        wait_valid("t5_next_timeout", 20);
        chk("t5_next_pc", instr_pc, 32'h0000_0204);

        // target with bit 1 set
        do_reset(0);
        wait_valid("t6_first_timeout", 20);
        do_redirect(32'h0, 32'h6, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (3) begin
            chk("t6_misalign", misalign_exc, 1'b1);
            chk("t6_no_req", imem_req, 1'b0);
            chk("t6_no_valid", instr_valid, 1'b0);
            tick();
        end
        do_redirect(32'h40, 32'h0, 1'b0);
        chk("t6_misalign_clear", misalign_exc, 1'b0);
        wait_valid("t6_valid_timeout", 20);
        chk("t6_pc", instr_pc, 32'h40);
`else
        wait_valid("t6_valid_timeout", 20);
        chk("t6_pc", instr_pc, 32'h4);
        chk("t6_misalign", misalign_exc, 1'b0);
`endif

        // randomized traffic against the reference model
        mem_gnt_dly = -1; mem_rv_dly = -1;
        do_reset(0);
        rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
